// File: rtl/trigger_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trigger_arbiter: picks one non-empty trigger_counter per cycle, pops it,   |
// | and holds the winner index as a valid/ready trigger.                       |
// | Build option: TRIGGER_ARBITER_RR_EN (round-robin; else fixed priority).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module trigger_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 8,
    parameter int ID_WIDTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS*WIDTH-1:0] current,
    output logic [NUM_PORTS-1:0]       pop_ready,
    output logic                       trigger_valid,
    output logic [ID_WIDTH-1:0]        trigger_id,
    input  logic                       trigger_ready
);

    // Reset pointer to the last port so that port 0 is scanned first.
    localparam logic [ID_WIDTH-1:0] C_LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_load;
    logic                 w_any;
    logic [ID_WIDTH-1:0]  w_sel;
    logic [ID_WIDTH-1:0]  r_last_grant;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign w_req[gi] = |current[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_load = !trigger_valid || trigger_ready;
    assign w_any  = |w_req;

`ifdef TRIGGER_ARBITER_RR_EN
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        w_sel = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && w_req[idx]) begin
                w_sel = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_sel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_req[i]) w_sel = ID_WIDTH'(i);
        end
    end

    // Pointer is still tracked in this build but does not steer selection.
    logic w_unused_last_grant;
    assign w_unused_last_grant = ^r_last_grant;
`endif

    always_comb begin
        pop_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop_ready[i] = rst_n && w_load && w_any && (w_sel == ID_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_valid <= 1'b0;
            trigger_id    <= '0;
            r_last_grant  <= C_LAST_PORT;
        end else if (w_load) begin
            if (w_any) begin
                trigger_valid <= 1'b1;
                trigger_id    <= w_sel;
                r_last_grant  <= w_sel;
            end else begin
                trigger_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trigger_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_trigger_arbiter: directed vectors plus counter-model sequences.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_trigger_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] current;
    logic [3:0]  pop_ready;
    logic        trigger_valid;
    logic [1:0]  trigger_id;
    logic        trigger_ready;

    int total;
    int bad;
    int cnt [4];
    logic [3:0] s_pop;
    logic       s_v;
    logic [1:0] s_id;

    trigger_arbiter #(.NUM_PORTS(4), .WIDTH(8), .ID_WIDTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .current      (current),
        .pop_ready    (pop_ready),
        .trigger_valid(trigger_valid),
        .trigger_id   (trigger_id),
        .trigger_ready(trigger_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, required finish");
        $fatal(1, "watchdog");
    end

`ifdef TRIGGER_ARBITER_RR_EN
    localparam logic [3:0] C_POP6 = 4'b0100;
    localparam logic [1:0] C_ID6  = 2'd2;
    localparam bit         C_RR   = 1'b1;
`else
    localparam logic [3:0] C_POP6 = 4'b0001;
    localparam logic [1:0] C_ID6  = 2'd0;
    localparam bit         C_RR   = 1'b0;
`endif

    typedef struct {
        logic [31:0] cur;
        logic        rdy;
        logic [3:0]  pop;
        logic        v;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cnt();
        for (int i = 0; i < 4; i++) current[i*8 +: 8] = 8'(cnt[i]);
    endtask

    // One cycle of counter-model stimulus: sample mid-cycle, apply pops at the edge.
    task automatic cycle(input logic rdy);
        drive_cnt();
        trigger_ready = rdy;
        @(negedge clk);
        s_pop = pop_ready;
        s_v   = trigger_valid;
        s_id  = trigger_id;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (s_pop[i]) cnt[i] = cnt[i] - 1;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        drive_cnt();
        trigger_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_pop [5];
        logic       exp_v   [5];
        logic [1:0] ids_a   [8];
        logic [1:0] ids_b   [3];
        total = 0;
        bad   = 0;

        tbl[0]  = '{32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{32'h00000100, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[2]  = '{32'h00000000, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[3]  = '{32'h02000000, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[4]  = '{32'h02000000, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[5]  = '{32'h00010001, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[6]  = '{32'h00010001, 1'b1, C_POP6,  1'b1, 2'd0};
        tbl[7]  = '{32'h00000000, 1'b0, 4'b0000, 1'b1, C_ID6};
        tbl[8]  = '{32'h00000000, 1'b1, 4'b0000, 1'b1, C_ID6};
        tbl[9]  = '{32'h00000000, 1'b0, 4'b0000, 1'b0, C_ID6};
        tbl[10] = '{32'h00070000, 1'b0, 4'b0100, 1'b0, C_ID6};
        tbl[11] = '{32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd2};

        // Reset with all counters non-zero
        rst_n = 1'b0;
        trigger_ready = 1'b1;
        for (int i = 0; i < 4; i++) cnt[i] = 5;
        drive_cnt();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pop", 32'(pop_ready), 32'h0);
        chk("rst_valid", 32'(trigger_valid), 32'h0);
        chk("rst_id", 32'(trigger_id), 32'h0);
        #1 rst_n = 1'b1;
        #1 chk("rel_pop", 32'(pop_ready), 32'b0001);
        @(posedge clk);
        cnt[0] = cnt[0] - 1;
        #1;
        cycle(1'b1);
        chk("rel_valid", 32'(s_v), 32'h1);
        chk("rel_id", 32'(s_id), 32'h0);

        // Directed vector table
        do_reset();
        for (int r = 0; r < 12; r++) begin
            current = tbl[r].cur;
            trigger_ready = tbl[r].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_pop", r), 32'(pop_ready), 32'(tbl[r].pop));
            chk($sformatf("tbl%0d_valid", r), 32'(trigger_valid), 32'(tbl[r].v));
            chk($sformatf("tbl%0d_id", r), 32'(trigger_id), 32'(tbl[r].id));
            @(posedge clk);
            #1;
        end

        // Single source drains three events back to back
        do_reset();
        cnt[2] = 3;
        exp_pop = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        exp_v   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1);
            chk($sformatf("single%0d_pop", c), 32'(s_pop), 32'(exp_pop[c]));
            chk($sformatf("single%0d_valid", c), 32'(s_v), 32'(exp_v[c]));
            if (exp_v[c]) chk($sformatf("single%0d_id", c), 32'(s_id), 32'd2);
        end

        // All four counters at 2
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 2;
        if (C_RR) ids_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        else      ids_a = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        cycle(1'b1);
        chk("all2_first_valid", 32'(s_v), 32'h0);
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1);
            chk($sformatf("all2_%0d_valid", c), 32'(s_v), 32'h1);
            chk($sformatf("all2_%0d_id", c), 32'(s_id), 32'(ids_a[c]));
        end
        cycle(1'b1);
        chk("all2_end_valid", 32'(s_v), 32'h0);

        // Ports 0 and 3 competing
        do_reset();
        cnt[0] = 2;
        cnt[3] = 1;
        if (C_RR) ids_b = '{2'd0, 2'd3, 2'd0};
        else      ids_b = '{2'd0, 2'd0, 2'd3};
        cycle(1'b1);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1);
            chk($sformatf("p03_%0d_valid", c), 32'(s_v), 32'h1);
            chk($sformatf("p03_%0d_id", c), 32'(s_id), 32'(ids_b[c]));
        end
        cycle(1'b1);
        chk("p03_end_valid", 32'(s_v), 32'h0);

        // Backpressure holds the trigger and blocks pops
        do_reset();
        cnt[1] = 1;
        cycle(1'b1);
        chk("bp_load_pop", 32'(s_pop), 32'b0010);
        cnt[3] = 1;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0);
            chk($sformatf("bp%0d_pop", c), 32'(s_pop), 32'h0);
            chk($sformatf("bp%0d_id", c), 32'(s_id), 32'd1);
            chk($sformatf("bp%0d_valid", c), 32'(s_v), 32'h1);
        end
        cycle(1'b1);
        chk("bp_rel_pop", 32'(s_pop), 32'b1000);
        chk("bp_rel_id", 32'(s_id), 32'd1);
        cycle(1'b1);
        chk("bp_next_id", 32'(s_id), 32'd3);
        chk("bp_next_valid", 32'(s_v), 32'h1);

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 4;
        repeat (3) cycle(1'b1);
        chk("arst_pre_valid", 32'(s_v), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(trigger_valid), 32'h0);
        chk("arst_pop", 32'(pop_ready), 32'h0);
        #1 rst_n = 1'b1;
        cycle(1'b1);
        chk("arst_resume_pop", 32'(s_pop), 32'b0001);
        chk("arst_resume_valid", 32'(s_v), 32'h0);
        cycle(1'b1);
        chk("arst_resume_id", 32'(s_id), 32'd0);
        chk("arst_resume_v", 32'(s_v), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
